// File: rtl/ram8_bank.sv
// ram8_bank: eight-word register bank with one-hot write decode, 8-way read
// mux and a sequenced bulk-clear engine.
// Optional build macro RAM8_BANK_RDREG_EN registers the read port (one-cycle
// read latency); without it the read path is purely combinational.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | normal operation, writes accepted, clear request watched
//   ST_CLEAR | zeroing word[r_cnt] each edge, writes and clears ignored
module ram8_bank #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic             load_i,
  input  logic [2:0]       address_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] out_o,
  output logic             busy_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_cnt;
  logic [2:0]       w_cnt_nxt;
  logic [7:0]       w_we;
  logic [7:0]       w_clr_we;
  logic [WIDTH-1:0] r_word [8];

  // State register and clear counter; reset aborts any running sequence.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic and the one-hot clear strobe for the word being zeroed.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_we    = 8'd0;
    unique case (r_state)
      ST_IDLE: begin
        if (clear_i) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = 3'd0;
        end
      end
      ST_CLEAR: begin
        w_clr_we = 8'd1 << r_cnt;
        if (r_cnt == 3'd7) begin
          // Counter wraps to 0 only here, on the way out.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // One-hot write decode; a clear request in the same cycle drops the write.
  always_comb begin
    w_we = 8'd0;
    if (load_i && (r_state == ST_IDLE) && !clear_i) begin
      w_we[address_i] = 1'b1;
    end
  end

  // Word storage: clear strobe and write strobe are never active together.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < 8; k++) begin
        r_word[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (w_clr_we[k]) begin
          r_word[k] <= '0;
        end else if (w_we[k]) begin
          r_word[k] <= in_i;
        end
      end
    end
  end

  assign busy_o = (r_state == ST_CLEAR);

`ifdef RAM8_BANK_RDREG_EN
  logic [WIDTH-1:0] r_out;

  // Registered read: captures the word as it stood before this edge's update.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_out <= '0;
    end else begin
      r_out <= r_word[address_i];
    end
  end

  assign out_o = r_out;
`else
  assign out_o = r_word[address_i];
`endif

endmodule

// File: tb/tb_ram8_bank.sv
// tb_ram8_bank: scoreboard bench for ram8_bank. A cycle model of the bank
// produces the expected read data and busy flag for every driven cycle; the
// expectation is queued at drive time and compared against the DUT on the
// following falling edge. Works for both read-port builds.
module tb_ram8_bank;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic         clr;
  logic [2:0]   addr;
  logic [W-1:0] din;
  wire  [W-1:0] dout;
  wire          busy;

  always #5 clk = ~clk;

  ram8_bank #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .in_i      (din),
    .load_i    (load),
    .address_i (addr),
    .clear_i   (clr),
    .out_o     (dout),
    .busy_o    (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [W-1:0] mdl [8];
  logic         mbusy;
  logic [2:0]   mcnt;
  logic [W-1:0] mout;

  logic [W:0]   q_exp [$];
  string        q_tag [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_out();
`ifdef RAM8_BANK_RDREG_EN
    return mout;
`else
    return mdl[addr];
`endif
  endfunction

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_edge();
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) mdl[k] = '0;
      mbusy = 1'b0;
      mcnt  = 3'd0;
      mout  = '0;
    end else begin
      mout = mdl[addr];
      if (mbusy) begin
        mdl[mcnt] = '0;
        if (mcnt == 3'd7) begin
          mbusy = 1'b0;
          mcnt  = 3'd0;
        end else begin
          mcnt = mcnt + 3'd1;
        end
      end else if (clr) begin
        mbusy = 1'b1;
        mcnt  = 3'd0;
      end else if (load) begin
        mdl[addr] = din;
      end
    end
  endtask

  // One clock cycle: drive, queue expectation, compare at negedge, step edge.
  task automatic cyc(input logic r, input logic ld, input logic cl,
                     input logic [2:0] a, input logic [W-1:0] d,
                     input string tag, input bit en = 1'b1);
    logic [W:0] e;
    string      t;
    rst_n = r;
    load  = ld;
    clr   = cl;
    addr  = a;
    din   = d;
    if (en) begin
      q_exp.push_back({mbusy, exp_out()});
      q_tag.push_back(tag);
    end
    @(negedge clk);
    if (en) begin
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      chk({t, "_out"}, 32'(dout), 32'(e[W-1:0]));
      chk({t, "_busy"}, 32'(busy), 32'(e[W]));
    end
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a, input string tag);
    cyc(1'b1, 1'b0, 1'b0, a, '0, tag);
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d, input string tag);
    cyc(1'b1, 1'b1, 1'b0, a, d, tag);
  endtask

  task automatic sweep(input string tag);
    for (int k = 0; k < 8; k++) rd(3'(k), tag);
    rd(3'd0, tag);
  endtask

  int blen;
  int guard;

  initial begin
    rst_n = 1'b0; load = 1'b0; clr = 1'b0; addr = '0; din = '0;
    mbusy = 1'b0; mcnt = '0; mout = '0;
    for (int k = 0; k < 8; k++) mdl[k] = '0;

    // Reset held two cycles, then read sweep
    cyc(1'b0, 1'b0, 1'b0, 3'd0, '0, "rst", 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, '0, "rst", 1'b0);
    sweep("rst_rd");

    // Fill and read back every word
    for (int k = 0; k < 8; k++) wr(3'(k), W'(16'h1000 + k), "fill_wr");
    sweep("fill_rd");

    // Single-cycle clear pulse while watching address 5
    cyc(1'b1, 1'b0, 1'b1, 3'd5, '0, "clr_req");
    blen = 0; guard = 0;
    while (busy && guard < 20) begin
      blen++; guard++;
      rd(3'd5, "clr_a5");
    end
    chk("clr_busy_len", 32'(blen), 32'd8);
    sweep("clr_rd");

    // Clear beats a simultaneous write; writes and clears ignored while busy
    wr(3'd3, 16'h3333, "pri_pre");
    cyc(1'b1, 1'b1, 1'b1, 3'd3, 16'hBEEF, "pri_clrld");
    blen = 0; guard = 0;
    while (busy && guard < 20) begin
      blen++; guard++;
      if (blen == 2)      cyc(1'b1, 1'b1, 1'b0, 3'd2, 16'hCAFE, "pri_ldbusy");
      else if (blen == 4) cyc(1'b1, 1'b0, 1'b1, 3'd2, '0, "pri_clrbusy");
      else                rd(3'd3, "pri_busy");
    end
    chk("pri_busy_len", 32'(blen), 32'd8);
    rd(3'd3, "pri_w3");
    rd(3'd2, "pri_w2");
    rd(3'd2, "pri_w2b");

    // Clear held high: back-to-back sequences separated by one idle cycle
    wr(3'd6, 16'h6006, "hold_pre");
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b1, 3'(i), '0, "hold");
    guard = 0;
    while (mbusy && guard < 20) begin
      guard++;
      rd(3'd6, "hold_drain");
    end
    chk("hold_drain_bound", 32'(guard < 20), 32'd1);

    // Reset in the middle of a clear
    for (int k = 0; k < 8; k++) wr(3'(k), 16'hFFFF, "mid_fill");
    cyc(1'b1, 1'b0, 1'b1, 3'd7, '0, "mid_req");
    rd(3'd7, "mid_b1");
    rd(3'd7, "mid_b2");
    cyc(1'b0, 1'b0, 1'b0, 3'd7, '0, "mid_rst");
    sweep("mid_rd");
    wr(3'd4, 16'h5A5A, "mid_wr");
    rd(3'd4, "mid_wrrd");
    rd(3'd4, "mid_wrrd");

    // Read latency and read-during-write to the same address
    wr(3'd0, 16'h1234, "lat_w0");
    wr(3'd1, 16'h00AA, "lat_w1");
    rd(3'd0, "lat_r0");
    rd(3'd1, "lat_r1");
    rd(3'd1, "lat_r1b");
    wr(3'd1, 16'h0055, "rdw_wr");
    rd(3'd1, "rdw_r1");
    rd(3'd1, "rdw_r1b");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
